// File: rtl/snn_ctrl_pkg.sv
// snn_ctrl_pkg: opcodes, loader states and defaults shared by the snn_layer_ctrl slice.
package snn_ctrl_pkg;
    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_RUN = 2'b10;
    localparam logic [1:0] OP_STOP = 2'b11;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;
    typedef enum logic [1:0] {IDLE = ST_IDLE, LOAD = ST_LOAD, COMMIT = ST_COMMIT} state_t;
    localparam int CFG_BYTES = 13;
    localparam logic [31:0] RESET_PARAMS_DEF = 32'h40_01_02_01;
endpackage

// File: rtl/snn_layer_ctrl_if.sv
// snn_layer_ctrl_if: byte-serial command/data valid/ready channel into snn_layer_ctrl.
interface snn_layer_ctrl_if;
    logic [7:0] in_data;
    logic in_valid;
    logic in_ready;
    modport master (output in_data, output in_valid, input in_ready);
    modport slave (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/snn_tick_timer.sv
// snn_tick_timer: periodic one-cycle enable pulse; a due tick is held off while hold is high.
module snn_tick_timer #(
    parameter int PERIOD_W = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic stop,
    input  logic hold,
    input  logic [PERIOD_W-1:0] period_m1,
    output logic enable,
    output logic running
);
    logic [PERIOD_W-1:0] cnt;
    logic [PERIOD_W-1:0] reload;
    logic fire;
    assign fire = running && cnt == '0 && !start && !stop && !hold;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt <= '0;
            reload <= '0;
            running <= 1'b0;
            enable <= 1'b0;
        end else begin
            enable <= fire;
            if (stop) begin
                running <= 1'b0;
                cnt <= '0;
            end else if (start) begin
                running <= 1'b1;
                cnt <= period_m1;
                reload <= period_m1;
            end else if (running && cnt != '0) cnt <= cnt - 1'b1;
            else if (fire) cnt <= reload;
        end
endmodule

// File: rtl/snn_layer_ctrl.sv
// snn_layer_ctrl: byte-serial config loader with atomic commit and step scheduler for the 3-neuron layer.
// Optional saturating per-neuron spike counters are built when SNN_SPIKE_CNT_EN is defined.
module snn_layer_ctrl
    import snn_ctrl_pkg::*;
#(
    parameter int NUM_W_BYTES = 9,
    parameter int NUM_P_BYTES = 4,
    parameter int PERIOD_W = 6,
    parameter logic [8*NUM_P_BYTES-1:0] RESET_PARAMS = RESET_PARAMS_DEF
) (
    input  logic clk,
    input  logic rst_n,
    snn_layer_ctrl_if.slave bus,
    input  logic [2:0] spike_in,
    output logic [8*NUM_W_BYTES-1:0] input_weights,
    output logic [8*NUM_P_BYTES-1:0] neuron_params,
    output logic enable,
    output logic running,
    output logic cfg_valid
`ifdef SNN_SPIKE_CNT_EN
    ,
    output logic [23:0] spike_cnt
`endif
);
    localparam int NB = NUM_W_BYTES + NUM_P_BYTES;
    localparam int CW = $clog2(NB);
    localparam logic [CW-1:0] LAST = CW'(NB - 1);
    state_t state;
    logic [CW-1:0] byte_cnt;
    logic [8*NB-1:0] shadow;
    logic accept;
    logic hdr;
    logic load_last;
    logic run_cmd;
    logic stop_cmd;
    logic [1:0] opcode;
    assign accept = bus.in_valid && bus.in_ready;
    assign opcode = bus.in_data[7:6];
    assign hdr = state == IDLE && accept && opcode != OP_NOP;
    assign run_cmd = hdr && opcode == OP_RUN;
    assign stop_cmd = hdr && opcode == OP_STOP;
    assign load_last = state == LOAD && accept && byte_cnt == LAST;
    // Bytes arrive MSB first, so shifting left leaves byte 0 at the top of the weight field.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            byte_cnt <= '0;
            shadow <= '0;
            bus.in_ready <= 1'b0;
            input_weights <= '0;
            neuron_params <= RESET_PARAMS;
            cfg_valid <= 1'b0;
        end else begin
            bus.in_ready <= !load_last;
            if (hdr && opcode == OP_LOAD) begin
                state <= LOAD;
                byte_cnt <= '0;
            end
            if (state == LOAD && accept) begin
                shadow <= {shadow[8*NB-9:0], bus.in_data};
                byte_cnt <= byte_cnt + 1'b1;
                if (load_last) state <= COMMIT;
            end
            if (state == COMMIT) begin
                input_weights <= shadow[8*NB-1 -: 8*NUM_W_BYTES];
                neuron_params <= shadow[8*NUM_P_BYTES-1:0];
                cfg_valid <= 1'b1;
                state <= IDLE;
            end
        end
    snn_tick_timer #(.PERIOD_W(PERIOD_W)) u_timer (
        .clk(clk),
        .rst_n(rst_n),
        .start(run_cmd),
        .stop(stop_cmd),
        .hold(state == COMMIT),
        .period_m1(bus.in_data[PERIOD_W-1:0]),
        .enable(enable),
        .running(running)
    );
`ifdef SNN_SPIKE_CNT_EN
    // Spikes answering a step appear the cycle after the enable pulse.
    logic en_d;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) en_d <= 1'b0;
        else en_d <= enable;
    for (genvar i = 0; i < 3; i++) begin : g_cnt
        logic [7:0] c;
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) c <= '0;
            else if (state == COMMIT) c <= '0;
            else if (en_d && spike_in[i] && c != 8'hFF) c <= c + 1'b1;
        assign spike_cnt[8*i +: 8] = c;
    end
`else
    logic unused_spike;
    assign unused_spike = ^spike_in;
`endif
endmodule
